// File: rtl/mac_accum_sched_pkg.sv
// Shared types and decode helpers for the MAC accumulate/drain sequencer.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam logic [1:0] MODE_LANE = 2'd0;
    localparam logic [1:0] MODE_PAIR = 2'd1;
    localparam logic [1:0] MODE_ALL  = 2'd2;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0   = 3'b001;
    localparam logic [2:0] SEL_L1   = 3'b011;
    localparam logic [2:0] SEL_L2   = 3'b101;
    localparam logic [2:0] SEL_L3   = 3'b111;
    localparam logic [2:0] SEL_P01  = 3'b010;
    localparam logic [2:0] SEL_P23  = 3'b110;
    localparam logic [2:0] SEL_ALL  = 3'b100;

    function automatic logic [2:0] slot_count(input logic [1:0] mode);
        case (mode)
            MODE_LANE: return 3'd4;
            MODE_PAIR: return 3'd2;
            default:   return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] slot_sel(input logic [1:0] mode, input logic [1:0] slot);
        case (mode)
            MODE_LANE: begin
                case (slot)
                    2'd0:    return SEL_L0;
                    2'd1:    return SEL_L1;
                    2'd2:    return SEL_L2;
                    default: return SEL_L3;
                endcase
            end
            MODE_PAIR: return slot[0] ? SEL_P23 : SEL_P01;
            default:   return SEL_ALL;
        endcase
    endfunction

endpackage

// File: rtl/mac_accum_sched_if.sv
// Config, input-vector and result-stream signals of the MAC sequencer.
interface mac_accum_sched_if #(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 25,
    parameter int unsigned VEC_LENGTH = 4,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic [1:0]                   cfg_mode;
    logic [LEN_WIDTH-1:0]         cfg_len;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [PSUM_WIDTH-1:0] in_data [VEC_LENGTH];
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH+1:0] out_data;
    logic [2:0]                   out_sel;
    logic                         out_last;

    modport master (
        output cfg_mode, cfg_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    modport slave (
        input  cfg_mode, cfg_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/mac_accum_sched_accum_lane_bank.sv
// Per-lane signed accumulators: load overwrites, add accumulates with wrap.
module accum_lane_bank #(
    parameter int unsigned VEC_LENGTH = 4,
    parameter int unsigned DATA_WIDTH = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic                         add_i,
    input  logic signed [DATA_WIDTH-1:0] data_i [VEC_LENGTH],
    output logic signed [DATA_WIDTH-1:0] lane_o [VEC_LENGTH]
);
    logic signed [DATA_WIDTH-1:0] lane_q [VEC_LENGTH];
    logic signed [DATA_WIDTH-1:0] lane_d [VEC_LENGTH];

    always_comb begin
        for (int i = 0; i < VEC_LENGTH; i++) begin
            lane_d[i] = lane_q[i];
            if (load_i) begin
                lane_d[i] = data_i[i];
            end else if (add_i) begin
                lane_d[i] = lane_q[i] + data_i[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VEC_LENGTH; i++) lane_q[i] <= '0;
        end else begin
            for (int i = 0; i < VEC_LENGTH; i++) lane_q[i] <= lane_d[i];
        end
    end

    assign lane_o = lane_q;
endmodule

// File: rtl/mac_accum_sched.sv
// Accumulates a configurable number of 4-lane partial-sum beats, then drains
// per-lane, pair or four-lane reductions onto a valid/ready stream.
module mac_accum_sched
    import mac_sched_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 25,
    parameter int unsigned VEC_LENGTH = 4,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    mac_accum_sched_if.slave   bus,
    output logic               busy
);
    if (VEC_LENGTH != 4) begin : g_vec_len_check
        $error("mac_accum_sched supports VEC_LENGTH == 4 only");
    end

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           slot_q, slot_d;
    logic [LEN_WIDTH-1:0] eff_len;
    logic                 lane_load, lane_add, last_slot;

    logic signed [DATA_WIDTH-1:0] data_ext [VEC_LENGTH];
    logic signed [DATA_WIDTH-1:0] lane_q   [VEC_LENGTH];
    logic signed [DATA_WIDTH:0]   pair_lo, pair_hi;
    logic signed [DATA_WIDTH+1:0] sum_all;

    always_comb begin
        for (int i = 0; i < VEC_LENGTH; i++) begin
            data_ext[i] = {{(DATA_WIDTH-PSUM_WIDTH){bus.in_data[i][PSUM_WIDTH-1]}}, bus.in_data[i]};
        end
    end

    accum_lane_bank #(
        .VEC_LENGTH(VEC_LENGTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_bank (
        .clk   (clk),
        .reset (reset),
        .load_i(lane_load),
        .add_i (lane_add),
        .data_i(data_ext),
        .lane_o(lane_q)
    );

    assign eff_len   = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;
    assign last_slot = (({1'b0, slot_q} + 3'd1) == slot_count(mode_q));

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        mode_d     = mode_q;
        slot_d     = slot_q;
        lane_load  = 1'b0;
        lane_add   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    lane_load  = 1'b1;
                    mode_d     = (bus.cfg_mode == 2'd3) ? MODE_ALL : bus.cfg_mode;
                    len_d      = eff_len;
                    beat_cnt_d = LEN_WIDTH'(1);
                    slot_d     = '0;
                    state_d    = (eff_len == LEN_WIDTH'(1)) ? StDrain : StAccum;
                end
            end
            StAccum: begin
                if (bus.in_valid) begin
                    lane_add   = 1'b1;
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    if (beat_cnt_d == len_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.out_ready) begin
                    if (last_slot) begin
                        state_d = StIdle;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            len_q      <= '0;
            mode_q     <= MODE_LANE;
            slot_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            slot_q     <= slot_d;
        end
    end

    // Every term is sign-extended by one bit per adder level so sums never wrap.
    always_comb begin
        pair_lo = {lane_q[0][DATA_WIDTH-1], lane_q[0]} + {lane_q[1][DATA_WIDTH-1], lane_q[1]};
        pair_hi = {lane_q[2][DATA_WIDTH-1], lane_q[2]} + {lane_q[3][DATA_WIDTH-1], lane_q[3]};
        sum_all = {pair_lo[DATA_WIDTH], pair_lo} + {pair_hi[DATA_WIDTH], pair_hi};
    end

    always_comb begin
        bus.in_ready  = (state_q != StDrain);
        bus.out_valid = (state_q == StDrain);
        busy          = (state_q != StIdle);
        bus.out_sel   = bus.out_valid ? slot_sel(mode_q, slot_q) : SEL_NONE;
        bus.out_last  = bus.out_valid && last_slot;
        case (bus.out_sel)
            SEL_L0:  bus.out_data = {{2{lane_q[0][DATA_WIDTH-1]}}, lane_q[0]};
            SEL_L1:  bus.out_data = {{2{lane_q[1][DATA_WIDTH-1]}}, lane_q[1]};
            SEL_L2:  bus.out_data = {{2{lane_q[2][DATA_WIDTH-1]}}, lane_q[2]};
            SEL_L3:  bus.out_data = {{2{lane_q[3][DATA_WIDTH-1]}}, lane_q[3]};
            SEL_P01: bus.out_data = {pair_lo[DATA_WIDTH], pair_lo};
            SEL_P23: bus.out_data = {pair_hi[DATA_WIDTH], pair_hi};
            SEL_ALL: bus.out_data = sum_all;
            default: bus.out_data = '0;
        endcase
    end
endmodule

// File: tb/tb_mac_accum_sched.sv
// Randomised and directed checks of mac_accum_sched against a lane-sum model.
module tb_mac_accum_sched;
    logic clk;
    logic reset;
    logic busy;

    mac_accum_sched_if bus ();

    mac_accum_sched dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int beats [256][4];
    int exp_sel [$];
    int exp_data [$];
    int obs_sel [$];
    int obs_data [$];
    bit obs_last [$];
    bit timed_out;
    int n_checks;
    int n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap_lane(input longint x);
        logic signed [24:0] t;
        t = x[24:0];
        return int'(t);
    endfunction

    function automatic int rand_psum();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Expected drain stream from the grouping rules applied to plain lane sums.
    task automatic model(input int mode, input int len);
        longint s [4];
        int l;
        l = (len == 0) ? 1 : len;
        for (int i = 0; i < 4; i++) s[i] = 0;
        for (int b = 0; b < l; b++)
            for (int i = 0; i < 4; i++) s[i] = longint'(wrap_lane(s[i] + beats[b][i]));
        exp_sel.delete();
        exp_data.delete();
        if (mode == 0) begin
            for (int i = 0; i < 4; i++) begin
                exp_sel.push_back(2 * i + 1);
                exp_data.push_back(int'(s[i]));
            end
        end else if (mode == 1) begin
            exp_sel.push_back(2);
            exp_data.push_back(int'(s[0] + s[1]));
            exp_sel.push_back(6);
            exp_data.push_back(int'(s[2] + s[3]));
        end else begin
            exp_sel.push_back(4);
            exp_data.push_back(int'(s[0] + s[1] + s[2] + s[3]));
        end
    endtask

    task automatic send(input int mode, input int len, input int gap_pct, input bit toggle_cfg,
                        input bit hold_valid);
        int l;
        l = (len == 0) ? 1 : len;
        for (int b = 0; b < l; b++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                if (toggle_cfg) bus.cfg_mode = 2'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) bus.in_data[i] = 16'(beats[b][i]);
            if (b == 0) begin
                bus.cfg_mode = 2'(mode);
                bus.cfg_len  = 8'(len);
            end else if (toggle_cfg) begin
                bus.cfg_mode = 2'($urandom);
                bus.cfg_len  = 8'($urandom);
            end
            tick();
        end
        bus.in_valid = hold_valid;
    endtask

    task automatic collect(input int n, input int ready_pct);
        int cycles;
        cycles = 0;
        timed_out = 1'b0;
        obs_sel.delete();
        obs_data.delete();
        obs_last.delete();
        while (obs_sel.size() < n) begin
            if (cycles >= 300) begin
                timed_out = 1'b1;
                break;
            end
            bus.out_ready = (int'($urandom_range(99)) < ready_pct);
            if (bus.out_valid && bus.out_ready) begin
                obs_sel.push_back(int'(bus.out_sel));
                obs_data.push_back(int'(bus.out_data));
                obs_last.push_back(bus.out_last);
                if (bus.out_last) bus.in_valid = 1'b0;
            end
            tick();
            cycles++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_mode = 2'd0;
        bus.cfg_len = 8'd1;
        for (int i = 0; i < 4; i++) bus.in_data[i] = '0;
        tick();
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
        n_checks++;
        if (bus.out_data !== '0 || bus.out_sel !== 3'b000 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out data=%0d sel=%b last=%b expected 0 000 0",
                     bus.out_data, bus.out_sel, bus.out_last);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mode_lane();
        int es [4] = '{1, 3, 5, 7};
        int ed [4] = '{1, -2, 3, -4};
        beats[0] = '{1, -2, 3, -4};
        send(0, 1, 0, 1'b0, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lane_latency out_valid=%b expected 1", bus.out_valid);
        end
        collect(4, 100);
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL lane_timeout got %0d results expected 4", obs_sel.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs_sel[k] != es[k] || obs_data[k] != ed[k] || obs_last[k] != (k == 3)) begin
                    n_fail++;
                    $display("FAIL lane_slot%0d sel=%0d data=%0d last=%0b expected %0d %0d %0b",
                             k, obs_sel[k], obs_data[k], obs_last[k], es[k], ed[k], k == 3);
                end
            end
        end
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lane_idle in_ready=%b busy=%b expected 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_mode_pair();
        int ed [2] = '{90, 210};
        for (int b = 0; b < 3; b++) beats[b] = '{10, 20, 30, 40};
        send(1, 3, 0, 1'b0, 1'b0);
        collect(2, 100);
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL pair_timeout got %0d results expected 2", obs_sel.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_sel[k] != 2 + 4 * k || obs_data[k] != ed[k] || obs_last[k] != (k == 1)) begin
                    n_fail++;
                    $display("FAIL pair_slot%0d sel=%0d data=%0d last=%0b expected %0d %0d %0b",
                             k, obs_sel[k], obs_data[k], obs_last[k], 2 + 4 * k, ed[k], k == 1);
                end
            end
        end
    endtask

    task automatic test_mode_all();
        int v [2] = '{32767, -32768};
        int ed [2] = '{262136, -262144};
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 2; b++) beats[b] = '{v[r], v[r], v[r], v[r]};
            send(2, 2, 0, 1'b0, 1'b0);
            collect(1, 100);
            n_checks++;
            if (timed_out || obs_sel[0] != 4 || obs_data[0] != ed[r] || obs_last[0] != 1'b1) begin
                n_fail++;
                $display("FAIL all_run%0d timeout=%0b sel=%0d data=%0d expected 4 %0d",
                         r, timed_out, obs_sel.size() > 0 ? obs_sel[0] : -1,
                         obs_data.size() > 0 ? obs_data[0] : 0, ed[r]);
            end
        end
    endtask

    task automatic test_backpressure();
        int held_sel;
        int held_data;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 4; i++) beats[b][i] = rand_psum();
        model(0, 2);
        send(0, 2, 0, 1'b0, 1'b1);
        collect(1, 100);
        held_sel  = int'(bus.out_sel);
        held_data = int'(bus.out_data);
        n_checks++;
        if (held_sel != exp_sel[1] || held_data != exp_data[1]) begin
            n_fail++;
            $display("FAIL bp_slot2 sel=%0d data=%0d expected %0d %0d",
                     held_sel, held_data, exp_sel[1], exp_data[1]);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (int'(bus.out_sel) != held_sel || int'(bus.out_data) != held_data ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d sel=%0d data=%0d in_ready=%b valid=%b expected %0d %0d 0 1",
                         c, bus.out_sel, bus.out_data, bus.in_ready, bus.out_valid,
                         held_sel, held_data);
            end
        end
        collect(3, 100);
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL bp_timeout got %0d results expected 3", obs_sel.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_sel[k] != exp_sel[k+1] || obs_data[k] != exp_data[k+1] ||
                    obs_last[k] != (k == 2)) begin
                    n_fail++;
                    $display("FAIL bp_slot%0d sel=%0d data=%0d expected %0d %0d",
                             k + 1, obs_sel[k], obs_data[k], exp_sel[k+1], exp_data[k+1]);
                end
            end
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_consume busy=%b expected 0", busy);
        end
    endtask

    task automatic test_gaps();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++) beats[b][i] = rand_psum();
        model(1, 4);
        send(1, 4, 40, 1'b1, 1'b0);
        collect(2, 60);
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL gap_timeout got %0d results expected 2", obs_sel.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_sel[k] != exp_sel[k] || obs_data[k] != exp_data[k] ||
                    obs_last[k] != (k == 1)) begin
                    n_fail++;
                    $display("FAIL gap_slot%0d sel=%0d data=%0d expected %0d %0d",
                             k, obs_sel[k], obs_data[k], exp_sel[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int mode;
        int len;
        for (int r = 0; r < 10; r++) begin
            mode = int'($urandom_range(3));
            len  = (r == 9) ? 255 : int'($urandom_range(6));
            for (int b = 0; b < 256; b++)
                for (int i = 0; i < 4; i++) beats[b][i] = rand_psum();
            model(mode, len);
            send(mode, len, 20, 1'b1, 1'b0);
            collect(exp_sel.size(), 70);
            n_checks++;
            if (timed_out) begin
                n_fail++;
                $display("FAIL rand%0d_timeout got %0d results expected %0d",
                         r, obs_sel.size(), exp_sel.size());
            end else begin
                for (int k = 0; k < exp_sel.size(); k++) begin
                    n_checks++;
                    if (obs_sel[k] != exp_sel[k] || obs_data[k] != exp_data[k] ||
                        obs_last[k] != (k == exp_sel.size() - 1)) begin
                        n_fail++;
                        $display("FAIL rand%0d_slot%0d mode=%0d len=%0d sel=%0d data=%0d expected %0d %0d",
                                 r, k, mode, len, obs_sel[k], obs_data[k], exp_sel[k], exp_data[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) beats[0][i] = rand_psum();
        send(0, 1, 0, 1'b0, 1'b0);
        collect(1, 100);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            bus.out_data !== '0 || bus.out_sel !== 3'b000 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async in_ready=%b valid=%b busy=%b data=%0d sel=%b last=%b",
                     bus.in_ready, bus.out_valid, busy, bus.out_data, bus.out_sel, bus.out_last);
        end
        tick();
        reset = 1'b0;
        tick();
        beats[0] = '{1, 1, 1, 1};
        send(2, 1, 0, 1'b0, 1'b0);
        collect(1, 100);
        n_checks++;
        if (timed_out || obs_sel[0] != 4 || obs_data[0] != 4 || obs_last[0] != 1'b1) begin
            n_fail++;
            $display("FAIL rst_reload timeout=%0b sel=%0d data=%0d expected 4 4", timed_out,
                     obs_sel.size() > 0 ? obs_sel[0] : -1, obs_data.size() > 0 ? obs_data[0] : 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mode_lane();
        test_mode_pair();
        test_mode_all();
        test_backpressure();
        test_gaps();
        test_random();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_accum_sched.md
Name: mac_accum_sched

Overview:
- Sequencer for the configurable 4-lane MAC reduction stage.
- Accepts per-lane partial-sum vectors from the PE array over a configurable number of beats and accumulates them per lane.
- Then drains reduced results onto a valid/ready output stream in one of three grouping modes: 4x1-lane, 2x2-lane or 1x4-lane.
- Sits between the PE-array column outputs and the output buffer writer.

Parameters:
- PSUM_WIDTH, 16: width of each signed input partial sum.
- DATA_WIDTH, 25: width of each signed lane accumulator.
- VEC_LENGTH, 4: lane count. Only 4 is supported; elaboration error otherwise.
- LEN_WIDTH, 8: width of the beat-count config.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  grouping: 0=per-lane, 1=pairs, 2=all-four, 3=treated as 2. Sampled on first accepted beat only.
- cfg_len  in  LEN_WIDTH  beats per accumulation; 0 treated as 1. Sampled on first accepted beat only.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  VEC_LENGTH x PSUM_WIDTH  signed lane partial sums (unpacked array, index = lane).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WIDTH+2  signed reduced result.
- out_sel  out  3  reduction code of the current result: 001/011/101/111 = lane 0/1/2/3; 010/110 = lanes 0+1 / 2+3; 100 = all four.
- out_last  out  1  final result of the current drain.
- busy  out  1  high in ACCUM or DRAIN.

Behaviour:
- Clock and reset: single clock; asynchronous, active-high reset. Reset clears the state to IDLE and zeroes all lane registers, counters and latched config. Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_sel=000, out_last=0, busy=0.
- Lane arithmetic: in_data is sign-extended to DATA_WIDTH before use. Lane accumulation wraps as two's complement with no saturation.
- Reduction: pair sums are DATA_WIDTH+1 bits; the four-lane sum is DATA_WIDTH+2 bits. All terms are sign-extended, so there is no overflow at the output width.
- States: IDLE, ACCUM, DRAIN. A transfer occurs when valid && ready.
- IDLE:
  - in_ready=1.
  - On transfer: lanes load the sign-extended in_data (overwrite, not add). cfg_mode and cfg_len are latched; beat_cnt=1.
  - Next state is DRAIN if the effective len is 1, else ACCUM.
- ACCUM:
  - in_ready=1.
  - On transfer: lane[i] += in_data[i]; beat_cnt++.
  - When the transfer makes beat_cnt equal len, next state is DRAIN.
  - in_valid low stalls with state held.
- DRAIN:
  - in_ready=0, out_valid=1. Lanes are frozen.
  - Slot sequence by mode:
    - mode 0: out_sel 001, 011, 101, 111 (4 slots).
    - mode 1: 010, 110 (2 slots).
    - mode 2/3: 100 (1 slot).
  - out_data and out_sel are decoded combinationally from the frozen lane registers and the slot counter only, with no input-to-output path.
  - out_data and out_sel must stay stable while out_valid && !out_ready.
  - out_last=1 on the final slot. A transfer on the final slot goes to IDLE; any other transfer advances the slot.
- Throughput:
  - An accumulation of len beats followed by S slots takes at least len+S cycles.
  - Input is blocked during DRAIN, so there is no overlap of consecutive accumulations.
  - A new first beat can be accepted in the cycle after the last-slot transfer.
- Boundary conditions:
  - cfg changes during ACCUM/DRAIN are ignored.
  - len=255 is legal.
  - in_valid held high across DRAIN is not consumed.
  - Reset asserted mid-ACCUM or mid-DRAIN aborts immediately with no output; the partial result is discarded.
- Latency: first result is visible (out_valid=1) in the cycle after the last input beat is accepted.

Decomposition:
- Package mac_sched_pkg:
  - state enum: IDLE/ACCUM/DRAIN.
  - mode constants: MODE_LANE, MODE_PAIR, MODE_ALL.
  - reduction-code constants: the 3-bit out_sel values.
  - function returning slot count per mode.
  - function mapping (mode, slot) to out_sel.
- Sub-module accum_lane_bank:
  - VEC_LENGTH signed DATA_WIDTH registers.
  - Inputs: load, add, sign-extended data.
  - Asynchronous reset to 0.
- Reduction adders and output mux stay in the top.

Test Plan:
- Mode 0, len=1, in_data={lane0=1, lane1=-2, lane2=3, lane3=-4}, out_ready=1:
  - out stream (sel, data) = (001,1), (011,-2), (101,3), (111,-4).
  - out_last only on the 4th result.
  - Then IDLE with in_ready=1.
- Mode 1, len=3, each beat {10,20,30,40}:
  - lanes become {30,60,90,120}.
  - out stream = (010,90), (110,210).
- Mode 2, len=2, each beat {32767 x4}:
  - out = (100, 262136). Checks sign extension and width growth with no wrap.
  - Repeat with {-32768 x4} -> -262144.
- Backpressure in mode 0: hold out_ready=0 for 5 cycles on slot 2.
  - out_data and out_sel stay stable.
  - in_ready=0 while in_valid=1; no beat consumed.
- Stall and gaps: mode 1, len=4, with in_valid gaps between beats.
  - Result equals the gap-free sum.
  - cfg_mode toggled during ACCUM has no effect.
- Reset mid-DRAIN (after slot 1 of mode 0):
  - Outputs return to their reset values asynchronously.
  - The next accumulation (mode 2, len=1, {1,1,1,1}) yields (100,4), proving the lanes were cleared and reloaded.
